// File: rtl/fb_ctrl_if.sv
// Write-requester bundle for fb_ctrl.
// Accelerator (a_*) and host (b_*) valid/ready write ports.
interface fb_ctrl_if #(
  parameter int ADDRESS_WIDTH = 20,
  parameter int DATA_WIDTH    = 15
);
  logic                     a_valid;
  logic                     a_ready;
  logic [ADDRESS_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0]    a_data;
  logic                     b_valid;
  logic                     b_ready;
  logic [ADDRESS_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0]    b_data;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/fb_ctrl.sv
// Framebuffer controller: round-robin write arbiter, clear engine, scan-out.
// Optional FB_OOB_CHECK_EN drops out-of-frame writes and flags oob_err.
module fb_ctrl #(
  parameter int ADDRESS_WIDTH = 20,
  parameter int DATA_WIDTH    = 15,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_clear,
  input  logic [DATA_WIDTH-1:0]    clear_color,
  output logic                     busy,
  output logic                     clear_done,
  fb_ctrl_if.slave                 req,
  input  logic                     frame_start,
  input  logic                     pix_req,
  output logic                     pix_valid,
  output logic                     ram_wr_en,
  output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  output logic                     ram_rd_en,
  output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
  output logic                     oob_err
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int NPIX = H_ACTIVE * V_ACTIVE;
  localparam logic [AW:0]   FB_PIX  = (AW+1)'(NPIX);
  localparam logic [AW-1:0] FB_LAST = AW'(NPIX - 1);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW:0]   clr_q, clr_d;
  logic          last_b_q, last_b_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          done_q, done_d;
  logic          oob_q, oob_d;
  logic [AW-1:0] scan_q, scan_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          pv_q, pv_d;

  logic          a_rdy, b_rdy;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          oob_hit;
  logic [AW-1:0] base;

  // Write side: FSM, clear engine, arbiter and registered RAM write port
  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    last_b_d  = last_b_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    din_d     = din_q;
    done_d    = 1'b0;
    oob_d     = oob_q;
    a_rdy     = 1'b0;
    b_rdy     = 1'b0;
    sel_addr  = req.a_addr;
    sel_data  = req.a_data;
    oob_hit   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (start_clear) begin
          state_d   = CLEAR;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          din_d     = clear_color;
          clr_d     = (AW+1)'(1);
        end else begin
          a_rdy = req.a_valid & (~req.b_valid | last_b_q);
          b_rdy = req.b_valid & (~req.a_valid | ~last_b_q);
          if (b_rdy) begin
            sel_addr = req.b_addr;
            sel_data = req.b_data;
          end
`ifdef FB_OOB_CHECK_EN
          oob_hit = ({1'b0, sel_addr} >= FB_PIX);
`endif
          if (a_rdy) last_b_d = 1'b0;
          if (b_rdy) last_b_d = 1'b1;
          if (a_rdy | b_rdy) begin
            if (oob_hit) begin
              oob_d = 1'b1;
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = sel_addr;
              din_d     = sel_data;
            end
          end
        end
      end
      CLEAR: begin
        if (clr_q == FB_PIX) begin
          state_d = RUN;
          clr_d   = '0;
          done_d  = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = clr_q[AW-1:0];
          clr_d     = clr_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Scan-out: read address stream with frame restart and wrap
  always_comb begin
    rd_en_d   = pix_req;
    rd_addr_d = rd_addr_q;
    scan_d    = scan_q;
    pv_d      = rd_en_q;
    base      = frame_start ? '0 : scan_q;
    if (pix_req) begin
      rd_addr_d = base;
      scan_d    = (base == FB_LAST) ? '0 : base + 1'b1;
    end else if (frame_start) begin
      scan_d = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      clr_q     <= '0;
      last_b_q  <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      din_q     <= '0;
      done_q    <= 1'b0;
      oob_q     <= 1'b0;
      scan_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      pv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_q     <= clr_d;
      last_b_q  <= last_b_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      din_q     <= din_d;
      done_q    <= done_d;
      oob_q     <= oob_d;
      scan_q    <= scan_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      pv_q      <= pv_d;
    end
  end

  assign req.a_ready = a_rdy;
  assign req.b_ready = b_rdy;
  assign busy        = (state_q == CLEAR);
  assign clear_done  = done_q;
  assign ram_wr_en   = wr_en_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_din     = din_q;
  assign ram_rd_en   = rd_en_q;
  assign ram_rd_addr = rd_addr_q;
  assign pix_valid   = pv_q;
`ifdef FB_OOB_CHECK_EN
  assign oob_err     = oob_q;
`else
  assign oob_err     = 1'b0;
`endif
endmodule

// File: tb/tb_fb_ctrl.sv
// Directed bench for fb_ctrl with an 8-pixel (4x2) frame.
// Expectations follow the FB_OOB_CHECK_EN setting of the build.
module tb_fb_ctrl;
  localparam int AW = 20;
  localparam int DW = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_clear = 1'b0;
  logic [DW-1:0] clear_color = '0;
  logic          busy, clear_done;
  logic          frame_start = 1'b0;
  logic          pix_req = 1'b0;
  logic          pix_valid;
  logic          ram_wr_en, ram_rd_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_din;
  logic          oob_err;

  int n_chk = 0;
  int n_fail = 0;

  fb_ctrl_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) rq ();

  fb_ctrl #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
    .H_ACTIVE(4), .V_ACTIVE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start_clear(start_clear), .clear_color(clear_color),
    .busy(busy), .clear_done(clear_done),
    .req(rq.slave),
    .frame_start(frame_start), .pix_req(pix_req),
    .pix_valid(pix_valid),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_din(ram_din),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    rq.a_valid = 1'b0; rq.a_addr = '0; rq.a_data = '0;
    rq.b_valid = 1'b0; rq.b_addr = '0; rq.b_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  logic [AW-1:0] exp_rd [6];
  logic          exp_a;
  logic          exp_oob;

  initial begin
    idle_reqs();
    do_reset();

    // reset values
    chk("rst_busy", busy, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_a_ready", rq.a_ready, 0);
    chk("rst_b_ready", rq.b_ready, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_wr_addr", ram_wr_addr, 0);
    chk("rst_din", ram_din, 0);
    chk("rst_rd_en", ram_rd_en, 0);
    chk("rst_rd_addr", ram_rd_addr, 0);
    chk("rst_oob", oob_err, 0);

    // single accelerator write
    rq.a_valid = 1'b1; rq.a_addr = 5; rq.a_data = 15'h7C00;
    #1;
    chk("a1_ready", rq.a_ready, 1);
    chk("a1_b_ready", rq.b_ready, 0);
    step();
    idle_reqs();
    chk("a1_wr_en", ram_wr_en, 1);
    chk("a1_wr_addr", ram_wr_addr, 5);
    chk("a1_din", ram_din, 15'h7C00);
    step();
    chk("a1_wr_en_off", ram_wr_en, 0);

    // round robin from a fresh pointer: A,B,A,B
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rq.a_valid = 1'b1; rq.a_addr = AW'(10 + i); rq.a_data = 15'h0011;
      rq.b_valid = 1'b1; rq.b_addr = AW'(20 + i); rq.b_data = 15'h0022;
      exp_a = (i % 2 == 0);
      #1;
      chk("rr_a_ready", rq.a_ready, exp_a);
      chk("rr_b_ready", rq.b_ready, !exp_a);
      step();
      chk("rr_wr_addr", ram_wr_addr, exp_a ? 10 + i : 20 + i);
      chk("rr_din", ram_din, exp_a ? 15'h0011 : 15'h0022);
    end
    rq.a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rq.b_addr = AW'(30 + i);
      #1;
      chk("bonly_b_ready", rq.b_ready, 1);
      chk("bonly_a_ready", rq.a_ready, 0);
      step();
      chk("bonly_wr_addr", ram_wr_addr, 30 + i);
    end
    idle_reqs();
    step();

    // clear with accelerator waiting
    rq.a_valid = 1'b1; rq.a_addr = 3; rq.a_data = 15'h0001;
    start_clear = 1'b1; clear_color = 15'h03E0;
    #1;
    chk("clr_n_a_ready", rq.a_ready, 0);
    step();
    start_clear = 1'b0; clear_color = 15'h1234;
    for (int k = 0; k < 8; k++) begin
      chk("clr_busy", busy, 1);
      chk("clr_wr_en", ram_wr_en, 1);
      chk("clr_wr_addr", ram_wr_addr, k);
      chk("clr_din", ram_din, 15'h03E0);
      chk("clr_a_ready", rq.a_ready, 0);
      chk("clr_done_early", clear_done, 0);
      step();
    end
    chk("clr_done", clear_done, 1);
    chk("clr_busy_off", busy, 0);
    chk("clr_wr_en_off", ram_wr_en, 0);
    chk("clr_a_ready_after", rq.a_ready, 1);
    step();
    idle_reqs();
    chk("clr_done_pulse", clear_done, 0);
    chk("post_clr_wr_en", ram_wr_en, 1);
    chk("post_clr_wr_addr", ram_wr_addr, 3);
    chk("post_clr_din", ram_din, 15'h0001);

    // scan: 10 requests wrap 0..7,0,1
    pix_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("scan_rd_en", ram_rd_en, 1);
      chk("scan_rd_addr", ram_rd_addr, i % 8);
      chk("scan_pix_valid", pix_valid, i >= 1);
    end
    pix_req = 1'b0;
    step();
    chk("scan_rd_en_off", ram_rd_en, 0);
    chk("scan_pv_tail", pix_valid, 1);
    step();
    chk("scan_pv_off", pix_valid, 0);

    // frame_start with the 5th request
    exp_rd[0] = 2; exp_rd[1] = 3; exp_rd[2] = 4;
    exp_rd[3] = 5; exp_rd[4] = 0; exp_rd[5] = 1;
    for (int i = 0; i < 6; i++) begin
      pix_req = 1'b1;
      frame_start = (i == 4);
      step();
      chk("fs_rd_addr", ram_rd_addr, exp_rd[i]);
    end
    pix_req = 1'b0; frame_start = 1'b0;
    step();

    // out-of-frame host write
`ifdef FB_OOB_CHECK_EN
    exp_oob = 1'b1;
`else
    exp_oob = 1'b0;
`endif
    rq.b_valid = 1'b1; rq.b_addr = 8; rq.b_data = 15'h0ABC;
    #1;
    chk("oob_b_ready", rq.b_ready, 1);
    step();
    idle_reqs();
    chk("oob_wr_en", ram_wr_en, !exp_oob);
    if (!exp_oob) chk("oob_wr_addr", ram_wr_addr, 8);
    chk("oob_err", oob_err, exp_oob);
    rq.a_valid = 1'b1; rq.a_addr = 2; rq.a_data = 15'h0055;
    step();
    idle_reqs();
    chk("oob_next_wr_en", ram_wr_en, 1);
    chk("oob_next_wr_addr", ram_wr_addr, 2);
    step();
    chk("oob_sticky", oob_err, exp_oob);

    // reset during the third clear cycle
    start_clear = 1'b1; clear_color = 15'h7FFF;
    step();
    start_clear = 1'b0;
    step();
    step();
    chk("mid_busy", busy, 1);
    chk("mid_wr_addr", ram_wr_addr, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_en", ram_wr_en, 0);
    chk("mid_rst_wr_addr", ram_wr_addr, 0);
    chk("mid_rst_din", ram_din, 0);
    chk("mid_rst_oob", oob_err, 0);
    chk("mid_rst_a_ready", rq.a_ready, 0);
    step();
    rst_n = 1'b1;
    rq.a_valid = 1'b1; rq.a_addr = 6; rq.a_data = 15'h0066;
    #1;
    chk("mid_a_ready", rq.a_ready, 1);
    step();
    idle_reqs();
    chk("mid_wr_en", ram_wr_en, 1);
    chk("mid_wr_addr2", ram_wr_addr, 6);
    for (int i = 0; i < 10; i++) begin
      chk("mid_no_done", clear_done, 0);
      chk("mid_no_busy", busy, 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
